// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage 16-bit core: opcodes, forwarding selects,
// shadow stage records and opcode-class helpers.
package cpu_pkg;

  localparam int OPC_BITS = 4;
  localparam int IDX_BITS = 5;

  localparam logic [OPC_BITS-1:0] OP_NOP    = 4'd0;
  localparam logic [OPC_BITS-1:0] OP_ADD    = 4'd1;
  localparam logic [OPC_BITS-1:0] OP_SUB    = 4'd2;
  localparam logic [OPC_BITS-1:0] OP_ADDI   = 4'd3;
  localparam logic [OPC_BITS-1:0] OP_SHLLI  = 4'd4;
  localparam logic [OPC_BITS-1:0] OP_SHRLI  = 4'd5;
  localparam logic [OPC_BITS-1:0] OP_CMP    = 4'd6;
  localparam logic [OPC_BITS-1:0] OP_LOAD   = 4'd7;
  localparam logic [OPC_BITS-1:0] OP_LOADI  = 4'd8;
  localparam logic [OPC_BITS-1:0] OP_STORE  = 4'd9;
  localparam logic [OPC_BITS-1:0] OP_JUMP   = 4'd10;
  localparam logic [OPC_BITS-1:0] OP_JUMPL  = 4'd11;
  localparam logic [OPC_BITS-1:0] OP_JUMPG  = 4'd12;
  localparam logic [OPC_BITS-1:0] OP_JUMPE  = 4'd13;
  localparam logic [OPC_BITS-1:0] OP_JUMPNE = 4'd14;
  localparam logic [OPC_BITS-1:0] OP_MOV    = 4'd15;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam int EX_S  = 0;
  localparam int MEM_S = 1;
  localparam int WB_S  = 2;

  typedef struct packed {
    logic                valid;
    logic [OPC_BITS-1:0] opcode;
    logic [IDX_BITS-1:0] dest;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '{valid: 1'b0, opcode: OP_NOP, dest: '0};

  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FLUSH} hz_state_t;

  function automatic logic is_writer(input logic [OPC_BITS-1:0] op);
    return op inside {OP_SUB, OP_ADD, OP_ADDI, OP_SHLLI, OP_SHRLI,
                      OP_LOAD, OP_LOADI, OP_MOV};
  endfunction

  function automatic logic uses_src1(input logic [OPC_BITS-1:0] op);
    return op inside {OP_SUB, OP_ADD, OP_ADDI, OP_SHLLI, OP_SHRLI,
                      OP_CMP, OP_LOAD, OP_STORE, OP_MOV};
  endfunction

  function automatic logic uses_src2(input logic [OPC_BITS-1:0] op);
    return op inside {OP_SUB, OP_ADD, OP_CMP, OP_STORE};
  endfunction

  function automatic logic is_jump(input logic [OPC_BITS-1:0] op);
    return op inside {OP_JUMP, OP_JUMPL, OP_JUMPG, OP_JUMPE, OP_JUMPNE};
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_branch_resolve.sv
// Taken/not-taken decision for the instruction in EX, from its opcode and the
// registered {ZF,GF,LF} flags.
module branch_resolve
  import cpu_pkg::*;
(
  input  logic                valid,
  input  logic [OPC_BITS-1:0] opcode,
  input  logic [2:0]          flags,
  output logic                taken
);

  always_comb begin
    taken = 1'b0;
    if (valid && is_jump(opcode)) begin
      case (opcode)
        OP_JUMP:   taken = 1'b1;
        OP_JUMPL:  taken = flags[0];
        OP_JUMPG:  taken = flags[1];
        OP_JUMPE:  taken = flags[2];
        OP_JUMPNE: taken = ~flags[2];
        default:   taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller: load-use stalls, branch flushes and
// registered forwarding selects. Optional counters under PERF_CNT_EN.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_IDX_W = IDX_BITS,
  parameter int OPC_W     = OPC_BITS,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [OPC_W-1:0]     id_opcode,
  input  logic [REG_IDX_W-1:0] id_src1,
  input  logic [REG_IDX_W-1:0] id_src2,
  input  logic [REG_IDX_W-1:0] id_dest,
  input  logic                 ex_zf,
  input  logic                 ex_gf,
  input  logic                 ex_lf,
  output logic                 stall,
  output logic                 flush_id,
  output logic                 bubble_ex,
  output logic                 pc_sel_target,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b,
  output logic [2:0]           flags_q,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  stage_t    stage_q [3];
  hz_state_t state;
  logic      taken;
  logic      load_use;

  branch_resolve u_branch (
    .valid  (stage_q[EX_S].valid),
    .opcode (stage_q[EX_S].opcode),
    .flags  (flags_q),
    .taken  (taken)
  );

  function automatic logic producer_hit(input stage_t s, input logic [REG_IDX_W-1:0] idx);
    return s.valid && is_writer(s.opcode) && (s.dest == idx);
  endfunction

  function automatic logic [1:0] fwd_select(input logic [REG_IDX_W-1:0] idx,
                                            input stage_t ex_s, input stage_t mem_s);
    if (producer_hit(ex_s, idx))  return FWD_EXMEM;
    if (producer_hit(mem_s, idx)) return FWD_MEMWB;
    return FWD_RF;
  endfunction

  // A taken branch outranks load-use: the ID instruction is wrong-path anyway.
  always_comb begin
    load_use = stage_q[EX_S].valid && (stage_q[EX_S].opcode == OP_LOAD) && id_valid &&
               ((uses_src1(id_opcode) && (stage_q[EX_S].dest == id_src1)) ||
                (uses_src2(id_opcode) && (stage_q[EX_S].dest == id_src2)));
    flush_id      = taken && (state != ST_FLUSH);
    pc_sel_target = flush_id;
    stall         = load_use && !flush_id && (state != ST_STALL);
    bubble_ex     = flush_id || stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) stage_q[i] <= STAGE_BUBBLE;
      fwd_a   <= FWD_RF;
      fwd_b   <= FWD_RF;
      flags_q <= 3'b000;
    end else begin
      stage_q[WB_S]  <= stage_q[MEM_S];
      stage_q[MEM_S] <= stage_q[EX_S];
      if (bubble_ex) begin
        stage_q[EX_S] <= STAGE_BUBBLE;
        fwd_a         <= FWD_RF;
        fwd_b         <= FWD_RF;
      end else begin
        stage_q[EX_S] <= '{valid: id_valid, opcode: id_opcode, dest: id_dest};
        fwd_a         <= fwd_select(id_src1, stage_q[EX_S], stage_q[MEM_S]);
        fwd_b         <= fwd_select(id_src2, stage_q[EX_S], stage_q[MEM_S]);
      end
      if (stage_q[EX_S].valid && (stage_q[EX_S].opcode == OP_CMP))
        flags_q <= {ex_zf, ex_gf, ex_lf};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (flush_id)   state <= ST_FLUSH;
          else if (stall) state <= ST_STALL;
        end
        ST_STALL: state <= ST_RUN;
        ST_FLUSH: state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1))    stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_id && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random
// instruction streams against an instruction-list reference model.
module tb_pipeline_hazard_ctrl;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [3:0]  id_opcode;
  logic [4:0]  id_src1, id_src2, id_dest;
  logic        ex_zf, ex_gf, ex_lf;
  logic        stall, flush_id, bubble_ex, pc_sel_target;
  logic [1:0]  fwd_a, fwd_b;
  logic [2:0]  flags_q;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_src1(id_src1), .id_src2(id_src2), .id_dest(id_dest),
    .ex_zf(ex_zf), .ex_gf(ex_gf), .ex_lf(ex_lf),
    .stall(stall), .flush_id(flush_id), .bubble_ex(bubble_ex),
    .pc_sel_target(pc_sel_target), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .flags_q(flags_q), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: list of in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct { bit v; int op; int d; } instr_t;
  instr_t pipe[$];
  bit [2:0] m_flags;
  int m_fa, m_fb, m_scnt, m_fcnt;
  bit exp_stall, exp_flush, exp_bubble;
  bit cur_v;
  int cur_op, cur_s1, cur_s2, cur_d;
  bit [2:0] cur_f;

  function automatic bit m_writer(int op);
    return op inside {OP_SUB, OP_ADD, OP_ADDI, OP_SHLLI, OP_SHRLI, OP_LOAD, OP_LOADI, OP_MOV};
  endfunction
  function automatic bit m_reads1(int op);
    return op inside {OP_SUB, OP_ADD, OP_ADDI, OP_SHLLI, OP_SHRLI, OP_CMP, OP_LOAD, OP_STORE, OP_MOV};
  endfunction
  function automatic bit m_reads2(int op);
    return op inside {OP_SUB, OP_ADD, OP_CMP, OP_STORE};
  endfunction
  function automatic bit m_taken(instr_t e, bit [2:0] f);
    if (!e.v) return 0;
    if (e.op == OP_JUMP) return 1;
    if (e.op == OP_JUMPL) return f[0];
    if (e.op == OP_JUMPG) return f[1];
    if (e.op == OP_JUMPE) return f[2];
    if (e.op == OP_JUMPNE) return !f[2];
    return 0;
  endfunction
  function automatic int m_src_sel(int idx, instr_t near, instr_t far);
    if (near.v && m_writer(near.op) && near.d == idx) return 1;
    if (far.v && m_writer(far.op) && far.d == idx) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    pipe = {};
    repeat (3) pipe.push_back('{v: 0, op: OP_NOP, d: 0});
    m_flags = 3'b000; m_fa = 0; m_fb = 0; m_scnt = 0; m_fcnt = 0;
    exp_stall = 0; exp_flush = 0; exp_bubble = 0;
  endtask

  task automatic drive(input bit v, input int op, input int s1, input int s2,
                       input int d, input bit [2:0] f);
    bit lu, tk;
    id_valid = v; id_opcode = 4'(op); id_src1 = 5'(s1); id_src2 = 5'(s2); id_dest = 5'(d);
    {ex_zf, ex_gf, ex_lf} = f;
    cur_v = v; cur_op = op; cur_s1 = s1; cur_s2 = s2; cur_d = d; cur_f = f;
    tk = m_taken(pipe[0], m_flags);
    lu = pipe[0].v && pipe[0].op == OP_LOAD && v &&
         ((m_reads1(op) && pipe[0].d == s1) || (m_reads2(op) && pipe[0].d == s2));
    exp_flush  = tk;
    exp_stall  = lu && !tk;
    exp_bubble = tk || lu;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    m_fa = exp_bubble ? 0 : m_src_sel(cur_s1, pipe[0], pipe[1]);
    m_fb = exp_bubble ? 0 : m_src_sel(cur_s2, pipe[0], pipe[1]);
    if (pipe[0].v && pipe[0].op == OP_CMP) m_flags = cur_f;
`ifdef PERF_CNT_EN
    if (exp_stall && m_scnt < 65535) m_scnt++;
    if (exp_flush && m_fcnt < 65535) m_fcnt++;
`endif
    if (exp_bubble) pipe.push_front('{v: 0, op: OP_NOP, d: 0});
    else            pipe.push_front('{v: cur_v, op: cur_op, d: cur_d});
    void'(pipe.pop_back());
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin drive(0, OP_NOP, 0, 0, 0, 3'b000); tick(); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive(0, OP_NOP, 0, 0, 0, 3'b000);
    #1;
    checks++;
    if ({stall, flush_id, bubble_ex, pc_sel_target, fwd_a, fwd_b, flags_q} !== 11'b0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %b want 0",
        {stall, flush_id, bubble_ex, pc_sel_target, fwd_a, fwd_b, flags_q});
    end
    @(posedge clk); #1; rst_n = 1'b1;
    drive(1, OP_CMP, 1, 2, 0, 3'b000); tick();
    drive(0, OP_NOP, 0, 0, 0, 3'b101); tick();
    checks++;
    if (flags_q !== 3'b101) begin errors++; $display("[TB] FAIL cmp_flags: got %b want 101", flags_q); end
    drive(1, OP_LOAD, 0, 0, 3, 3'b000); tick();
    drive(1, OP_ADD, 3, 1, 4, 3'b000);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_stall: got %b want 1", stall); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stall, bubble_ex, flush_id, pc_sel_target, flags_q, fwd_a, fwd_b} !== 11'b0) begin
      errors++; $display("[TB] FAIL midstall_reset: got %b want 0",
        {stall, bubble_ex, flush_id, pc_sel_target, flags_q, fwd_a, fwd_b});
    end
    model_reset();
    @(posedge clk); #1; rst_n = 1'b1;
    drive(1, OP_ADD, 3, 1, 4, 3'b000);
    checks++;
    if ({stall, bubble_ex} !== 2'b00) begin
      errors++; $display("[TB] FAIL post_reset_run: got %b want 00", {stall, bubble_ex});
    end
    tick();
  endtask

  task automatic test_forwarding();
    logic [1:0] want [3];
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b00;
    for (int gap = 0; gap < 3; gap++) begin
      idle(3);
      drive(1, OP_ADD, 0, 1, 2, 3'b000); tick();
      idle(gap);
      drive(1, OP_SUB, 1, 2, 5, 3'b000); tick();
      checks++;
      if (fwd_b !== want[gap]) begin
        errors++; $display("[TB] FAIL fwd_b_gap%0d: got %b want %b", gap, fwd_b, want[gap]);
      end
      checks++;
      if (fwd_a !== 2'b00) begin
        errors++; $display("[TB] FAIL fwd_a_gap%0d: got %b want 00", gap, fwd_a);
      end
    end
  endtask

  task automatic test_load_use();
    idle(3);
    drive(1, OP_LOAD, 0, 0, 3, 3'b000); tick();
    drive(1, OP_ADD, 3, 4, 6, 3'b000);
    checks++;
    if ({stall, bubble_ex, flush_id, pc_sel_target} !== 4'b1100) begin
      errors++; $display("[TB] FAIL lu_first: got %b want 1100", {stall, bubble_ex, flush_id, pc_sel_target});
    end
    tick();
    drive(1, OP_ADD, 3, 4, 6, 3'b000);
    checks++;
    if ({stall, bubble_ex} !== 2'b00) begin
      errors++; $display("[TB] FAIL lu_second: got %b want 00", {stall, bubble_ex});
    end
    tick();
    checks++;
    if ({fwd_a, fwd_b} !== 4'b1000) begin
      errors++; $display("[TB] FAIL lu_fwd: got %b want 1000", {fwd_a, fwd_b});
    end
  endtask

  task automatic test_branch();
    idle(3);
    drive(1, OP_CMP, 1, 2, 0, 3'b000); tick();
    drive(1, OP_JUMPG, 0, 0, 0, 3'b010);
    checks++;
    if (flush_id !== 1'b0) begin errors++; $display("[TB] FAIL cmp_not_branch: got %b want 0", flush_id); end
    tick();
    checks++;
    if (flags_q !== 3'b010) begin errors++; $display("[TB] FAIL gf_flags: got %b want 010", flags_q); end
    drive(1, OP_ADD, 1, 1, 7, 3'b000);
    checks++;
    if ({pc_sel_target, flush_id, bubble_ex, stall} !== 4'b1110) begin
      errors++; $display("[TB] FAIL jumpg_taken: got %b want 1110", {pc_sel_target, flush_id, bubble_ex, stall});
    end
    tick();
    drive(0, OP_NOP, 0, 0, 0, 3'b000);
    checks++;
    if ({pc_sel_target, flush_id, bubble_ex, stall} !== 4'b0000) begin
      errors++; $display("[TB] FAIL jumpg_one_cycle: got %b want 0000", {pc_sel_target, flush_id, bubble_ex, stall});
    end
    tick();
    drive(1, OP_CMP, 1, 2, 0, 3'b000); tick();
    drive(1, OP_JUMPL, 0, 0, 0, 3'b010); tick();
    drive(0, OP_NOP, 0, 0, 0, 3'b000);
    checks++;
    if ({pc_sel_target, flush_id, bubble_ex, stall} !== 4'b0000) begin
      errors++; $display("[TB] FAIL jumpl_not_taken: got %b want 0000", {pc_sel_target, flush_id, bubble_ex, stall});
    end
    tick();
  endtask

  task automatic test_priority();
    idle(3);
    drive(1, OP_JUMP, 0, 0, 3, 3'b000); tick();
    drive(1, OP_ADD, 3, 3, 5, 3'b000);
    checks++;
    if ({flush_id, pc_sel_target, bubble_ex, stall} !== 4'b1110) begin
      errors++; $display("[TB] FAIL jump_priority: got %b want 1110", {flush_id, pc_sel_target, bubble_ex, stall});
    end
    tick();
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      errors++; $display("[TB] FAIL flush_bubble_fwd: got %b want 0000", {fwd_a, fwd_b});
    end
    idle(1);
  endtask

  task automatic test_counters();
    rst_n = 1'b0; #1; model_reset();
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (3) begin
      drive(1, OP_LOAD, 0, 0, 3, 3'b000); tick();
      drive(1, OP_ADD, 3, 1, 6, 3'b000); tick();
      drive(1, OP_ADD, 3, 1, 6, 3'b000); tick();
    end
    repeat (2) begin
      drive(1, OP_JUMP, 0, 0, 0, 3'b000); tick();
      idle(1);
    end
    idle(1);
`ifdef PERF_CNT_EN
    checks++;
    if (stall_cnt !== 16'd3) begin errors++; $display("[TB] FAIL stall_cnt: got %0d want 3", stall_cnt); end
    checks++;
    if (flush_cnt !== 16'd2) begin errors++; $display("[TB] FAIL flush_cnt: got %0d want 2", flush_cnt); end
`else
    checks++;
    if ({stall_cnt, flush_cnt} !== 32'd0) begin
      errors++; $display("[TB] FAIL cnt_tied: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
`endif
  endtask

  task automatic test_random();
    int e_sc, e_fc;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 15), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), 3'($urandom_range(0, 7)));
      checks++;
      if ({stall, flush_id, pc_sel_target, bubble_ex} !== {exp_stall, exp_flush, exp_flush, exp_bubble}) begin
        errors++; $display("[TB] FAIL rnd_ctrl cyc%0d: got %b want %b", n,
          {stall, flush_id, pc_sel_target, bubble_ex}, {exp_stall, exp_flush, exp_flush, exp_bubble});
      end
      tick();
      checks++;
      if (fwd_a !== 2'(m_fa) || fwd_b !== 2'(m_fb)) begin
        errors++; $display("[TB] FAIL rnd_fwd cyc%0d: got %b/%b want %0d/%0d", n, fwd_a, fwd_b, m_fa, m_fb);
      end
      checks++;
      if (flags_q !== m_flags) begin
        errors++; $display("[TB] FAIL rnd_flags cyc%0d: got %b want %b", n, flags_q, m_flags);
      end
      e_sc = m_scnt; e_fc = m_fcnt;
      checks++;
      if (stall_cnt !== 16'(e_sc) || flush_cnt !== 16'(e_fc)) begin
        errors++; $display("[TB] FAIL rnd_cnt cyc%0d: got %0d/%0d want %0d/%0d", n, stall_cnt, flush_cnt, e_sc, e_fc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_priority();
    test_counters();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
